ffd_shift_universal: RTL and testbench
======================================

Name: ffd_shift_universal

Overview:
- Parametrised successor to the single-bit D flip-flop: a WIDTH-bit register bank built from D-type storage.
- Adds parallel load, clear, shift, rotate and arithmetic-shift modes, a clock enable and serial in/out.
- Adds a multi-cycle "shift by N" command sequenced by an internal counter with a busy/done handshake.
- Sits in the datapath wherever operands are staged, serialised or scaled by powers of two.

Parameters:
- WIDTH, 8, register width in bits (>= 2).
- CNT_W, 4, width of shift-amount field; max command amount is 2^CNT_W-1.
- RST_VAL, 0, value loaded into Q on reset (WIDTH bits).

Ports:
- clk  in  1  clock; all state updates on the falling edge of clk.
- rst  in  1  synchronous active-low reset, sampled on the falling edge of clk.
- en  in  1  clock enable; 0 freezes all state.
- mode  in  3  operation select, see Behaviour.
- start  in  1  request multi-cycle shift of amt steps using mode.
- amt  in  CNT_W  shift count for start.
- D  in  WIDTH  parallel load data.
- sin  in  1  serial input bit.
- Q  out  WIDTH  register contents (registered).
- sout  out  1  last bit shifted/rotated out (registered).
- busy  out  1  high while a multi-cycle command is executing.
- done  out  1  one-cycle pulse on completion of a multi-cycle command.

Behaviour:
- Reset: rst=0 at a falling edge has top priority and overrides en. Results: Q=RST_VAL, sout=0, busy=0, done=0, cnt=0, state=IDLE.
- done is a pulse. It is cleared on every edge unless set on that edge, including edges with en=0.
- With en=0, all other state holds. Any start request is lost.
- mode encoding, one step per edge:
  - 000 HOLD.
  - 001 LOAD: Q=D.
  - 010 SHL: Q={Q[W-2:0],sin}; sout=Q[W-1].
  - 011 SHR: Q={sin,Q[W-1:1]}; sout=Q[0].
  - 100 ROL: Q={Q[W-2:0],Q[W-1]}; sout=Q[W-1].
  - 101 ROR: Q={Q[0],Q[W-1:1]}; sout=Q[0].
  - 110 ASR: Q={Q[W-1],Q[W-1:1]}; sout=Q[0].
  - 111 CLR: Q=0.
  - sout is unchanged for 000, 001 and 111.
- State IDLE, en=1:
  - If start=1, mode is in 010..110 and amt!=0: latch mode into cmd and amt into cnt. Q and sout are unchanged on this edge. busy=1, go to BUSY.
  - Otherwise execute mode for one step; start is ignored.
- State BUSY, en=1:
  - Execute one step of latched cmd. sin is sampled live each step.
  - cnt decrements.
  - If cnt was 1: go to IDLE, busy=0, done=1 on the same edge as the final step.
  - mode, D, start and amt are ignored while busy.
- Latency: the command occupies amt+1 edges from the start edge. Q holds the final result when done is seen high.
- A start issued on the edge after done is accepted (back-to-back commands allowed).
- Reset during BUSY aborts immediately. done is not asserted.
- amt=2^CNT_W-1 with WIDTH smaller than amt is legal:
  - Rotations wrap modulo WIDTH.
  - SHL/SHR fill entirely with sin.
  - ASR saturates to all sign bits.

Test Plan:
- Reset with RST_VAL=8'hA5: hold rst=0 across one falling edge with en=1, mode=001, D=8'hFF -> Q=8'hA5, sout=0, busy=0, done=0.
- Single-step modes on Q=8'b1001_0110, sin=1:
  - SHL -> 8'h2D, sout=1.
  - SHR -> 8'hCB, sout=0.
  - ROL -> 8'h2D, sout=1.
  - ROR -> 8'h4B, sout=0.
  - ASR -> 8'hCB, sout=0.
  - CLR -> 8'h00.
- Multi-cycle: Q=8'h81, start=1, mode=100, amt=3.
  - busy rises on the start edge.
  - Q is 8'h03, 8'h06, 8'h0C on the next 3 edges.
  - done=1 and busy=0 on the 3rd edge; done=0 on the following edge.
- Enable freeze: during a BUSY ASR of 8'h80 with amt=4, drop en for 2 edges after the first step.
  - Q holds 8'hC0 during the freeze.
  - Completes with 8'hF8; done is delayed by exactly 2 edges.
- Abort and ignore:
  - Reset asserted mid-BUSY -> Q=RST_VAL, busy=0, no done pulse.
  - Separately, start with amt=0, mode=010 -> single SHL step, busy stays 0.
  - Separately, start with mode=001 -> plain load, busy stays 0.
- Back-to-back: start a SHR with amt=2, sin=0, from 8'hF0. On the edge after done, start a SHL with amt=1, sin=1.
  - First result 8'h3C, second 8'h79.
  - busy low for exactly one cycle between the two commands.

Source files
------------

// File: rtl/ffd_shift_universal.sv
// Universal WIDTH-bit register: load/clear/shift/rotate/arithmetic-shift per falling edge,
// plus a counter-sequenced multi-step "shift by N" command with busy/done handshake.
module ffd_shift_universal #(
    parameter int               WIDTH   = 8,
    parameter int               CNT_W   = 4,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [2:0]       mode,
    input  logic             start,
    input  logic [CNT_W-1:0] amt,
    input  logic [WIDTH-1:0] D,
    input  logic             sin,
    output logic [WIDTH-1:0] Q,
    output logic             sout,
    output logic             busy,
    output logic             done
);

    typedef enum logic {S_IDLE, S_BUSY} state_t;

    state_t             state_q, state_d;
    logic [2:0]         cmd_q, cmd_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   q_q, q_d;
    logic               sout_q, sout_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    // One step of the selected operation; returns {sout, Q}.
    function automatic logic [WIDTH:0] step(
        input logic [2:0]       op,
        input logic [WIDTH-1:0] q,
        input logic             s_in,
        input logic             s_out,
        input logic [WIDTH-1:0] d
    );
        logic signed [WIDTH-1:0] q_s;
        q_s = q;
        case (op)
            3'b001:  step = {s_out, d};
            3'b010:  step = {q[WIDTH-1], q[WIDTH-2:0], s_in};
            3'b011:  step = {q[0], s_in, q[WIDTH-1:1]};
            3'b100:  step = {q[WIDTH-1], q[WIDTH-2:0], q[WIDTH-1]};
            3'b101:  step = {q[0], q[0], q[WIDTH-1:1]};
            3'b110:  step = {q[0], q_s >>> 1};
            3'b111:  step = {s_out, {WIDTH{1'b0}}};
            default: step = {s_out, q};
        endcase
    endfunction

    always_comb begin
        state_d = state_q;
        cmd_d   = cmd_q;
        cnt_d   = cnt_q;
        q_d     = q_q;
        sout_d  = sout_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        if (en) begin
            case (state_q)
                S_IDLE: begin
                    // Only shift/rotate modes with a nonzero count become multi-cycle commands.
                    if (start && (mode >= 3'b010) && (mode <= 3'b110) && (amt != '0)) begin
                        cmd_d   = mode;
                        cnt_d   = amt;
                        busy_d  = 1'b1;
                        state_d = S_BUSY;
                    end else begin
                        {sout_d, q_d} = step(mode, q_q, sin, sout_q, D);
                    end
                end
                S_BUSY: begin
                    {sout_d, q_d} = step(cmd_q, q_q, sin, sout_q, D);
                    cnt_d = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(negedge clk) begin
        if (!rst) begin
            state_q <= S_IDLE;
            cmd_q   <= 3'b000;
            cnt_q   <= '0;
            q_q     <= RST_VAL;
            sout_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cmd_q   <= cmd_d;
            cnt_q   <= cnt_d;
            q_q     <= q_d;
            sout_q  <= sout_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign Q    = q_q;
    assign sout = sout_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_ffd_shift_universal.sv
// Bench for ffd_shift_universal: directed scenarios plus randomized traffic against an
// arithmetic reference model of the register and command sequencer.
module tb_ffd_shift_universal;

    logic       clk = 1'b0;
    logic       rst, en, start, sin;
    logic [2:0] mode;
    logic [3:0] amt;
    logic [7:0] d;
    logic [7:0] q;
    logic       sout, busy, done;

    int checks = 0;
    int errors = 0;

    // Reference model state
    int m_q, m_sout, m_busy, m_done, m_cnt, m_cmd;

    always #5 clk = ~clk;

    ffd_shift_universal #(.WIDTH(8), .CNT_W(4), .RST_VAL(8'hA5)) dut (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .start(start), .amt(amt),
        .D(d), .sin(sin), .Q(q), .sout(sout), .busy(busy), .done(done)
    );

    task automatic model_apply(input int op);
        case (op)
            1: m_q = d;
            2: begin m_sout = m_q / 128; m_q = (m_q * 2 + sin) % 256; end
            3: begin m_sout = m_q % 2;   m_q = m_q / 2 + sin * 128; end
            4: begin m_sout = m_q / 128; m_q = (m_q * 2) % 256 + m_q / 128; end
            5: begin m_sout = m_q % 2;   m_q = m_q / 2 + (m_q % 2) * 128; end
            6: begin m_sout = m_q % 2;   m_q = m_q / 2 + ((m_q >= 128) ? 128 : 0); end
            7: m_q = 0;
            default: ;
        endcase
    endtask

    // One falling edge: model follows the inputs present at the edge, outputs sampled 1 after.
    task automatic cyc();
        @(negedge clk);
        if (!rst) begin
            m_q = 8'hA5; m_sout = 0; m_busy = 0; m_done = 0; m_cnt = 0;
        end else begin
            m_done = 0;
            if (en) begin
                if (m_busy == 0) begin
                    if (start && mode >= 2 && mode <= 6 && amt != 0) begin
                        m_cmd = mode; m_cnt = amt; m_busy = 1;
                    end else begin
                        model_apply(mode);
                    end
                end else begin
                    model_apply(m_cmd);
                    m_cnt = m_cnt - 1;
                    if (m_cnt == 0) begin m_busy = 0; m_done = 1; end
                end
            end
        end
        #1;
    endtask

    task automatic load(input logic [7:0] v);
        start = 0; mode = 3'b001; d = v;
        cyc();
        mode = 3'b000;
    endtask

    task automatic test_reset();
        rst = 0; en = 1; mode = 3'b001; d = 8'hFF; start = 0; amt = 0; sin = 0;
        cyc();
        checks++; if (q !== 8'hA5) begin errors++; $display("FAIL reset_q got %h exp a5", q); end
        checks++; if (sout !== 1'b0) begin errors++; $display("FAIL reset_sout got %b exp 0", sout); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", done); end
        rst = 1; mode = 3'b000;
        cyc();
        checks++; if (q !== 8'hA5) begin errors++; $display("FAIL hold_q got %h exp a5", q); end
    endtask

    task automatic test_single_modes();
        logic [7:0] exp_q [6] = '{8'h2D, 8'hCB, 8'h2D, 8'h4B, 8'hCB, 8'h00};
        logic       exp_s [6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        for (int i = 0; i < 6; i++) begin
            load(8'h96);
            mode = 3'(i + 2); sin = 1;
            cyc();
            checks++;
            if (q !== exp_q[i]) begin errors++; $display("FAIL mode%0d_q got %h exp %h", i + 2, q, exp_q[i]); end
            checks++;
            if (sout !== exp_s[i]) begin errors++; $display("FAIL mode%0d_sout got %b exp %b", i + 2, sout, exp_s[i]); end
        end
        mode = 3'b000; sin = 0;
    endtask

    task automatic test_multi();
        logic [7:0] exp_q [3] = '{8'h03, 8'h06, 8'h0C};
        load(8'h81);
        start = 1; mode = 3'b100; amt = 3;
        cyc();
        checks++; if (busy !== 1'b1 || q !== 8'h81) begin errors++; $display("FAIL multi_start busy %b q %h exp 1 81", busy, q); end
        // Garbage on mode/D/start must be ignored while busy.
        start = 1; mode = 3'b001; d = 8'h00; amt = 7;
        for (int i = 0; i < 3; i++) begin
            if (i == 2) begin start = 0; mode = 3'b000; end
            cyc();
            checks++; if (q !== exp_q[i]) begin errors++; $display("FAIL multi_q%0d got %h exp %h", i, q, exp_q[i]); end
            checks++;
            if (done !== (i == 2) || busy !== (i != 2)) begin
                errors++; $display("FAIL multi_hs%0d done %b busy %b exp %b %b", i, done, busy, i == 2, i != 2);
            end
        end
        cyc();
        checks++; if (done !== 1'b0 || q !== 8'h0C) begin errors++; $display("FAIL multi_after done %b q %h exp 0 0c", done, q); end
    endtask

    task automatic test_freeze();
        load(8'h80);
        start = 1; mode = 3'b110; amt = 4;
        cyc();
        start = 0; mode = 3'b000;
        cyc();
        checks++; if (q !== 8'hC0) begin errors++; $display("FAIL freeze_step1 got %h exp c0", q); end
        en = 0;
        for (int i = 0; i < 2; i++) begin
            cyc();
            checks++;
            if (q !== 8'hC0 || busy !== 1'b1 || done !== 1'b0) begin
                errors++; $display("FAIL freeze_hold%0d q %h busy %b done %b exp c0 1 0", i, q, busy, done);
            end
        end
        en = 1;
        cyc(); cyc();
        checks++; if (q !== 8'hF0 || done !== 1'b0) begin errors++; $display("FAIL freeze_pre q %h done %b exp f0 0", q, done); end
        cyc();
        checks++;
        if (q !== 8'hF8 || done !== 1'b1 || busy !== 1'b0) begin
            errors++; $display("FAIL freeze_end q %h done %b busy %b exp f8 1 0", q, done, busy);
        end
    endtask

    task automatic test_abort();
        load(8'h55);
        start = 1; mode = 3'b101; amt = 5;
        cyc();
        start = 0; mode = 3'b000;
        cyc();
        rst = 0;
        cyc();
        checks++;
        if (q !== 8'hA5 || busy !== 1'b0 || done !== 1'b0) begin
            errors++; $display("FAIL abort q %h busy %b done %b exp a5 0 0", q, busy, done);
        end
        rst = 1;
        cyc(); cyc();
        checks++; if (done !== 1'b0 || q !== 8'hA5) begin errors++; $display("FAIL abort_after done %b q %h exp 0 a5", done, q); end
        load(8'h96);
        start = 1; mode = 3'b010; amt = 0; sin = 1;
        cyc();
        checks++; if (q !== 8'h2D || busy !== 1'b0) begin errors++; $display("FAIL amt0 q %h busy %b exp 2d 0", q, busy); end
        start = 1; mode = 3'b001; d = 8'h3C; amt = 5;
        cyc();
        checks++; if (q !== 8'h3C || busy !== 1'b0) begin errors++; $display("FAIL startload q %h busy %b exp 3c 0", q, busy); end
        start = 0; mode = 3'b000; sin = 0;
    endtask

    task automatic test_back_to_back();
        load(8'hF0);
        start = 1; mode = 3'b011; amt = 2; sin = 0;
        cyc();
        start = 0; mode = 3'b000;
        cyc(); cyc();
        checks++;
        if (q !== 8'h3C || done !== 1'b1 || busy !== 1'b0) begin
            errors++; $display("FAIL b2b_first q %h done %b busy %b exp 3c 1 0", q, done, busy);
        end
        start = 1; mode = 3'b010; amt = 1; sin = 1;
        cyc();
        checks++;
        if (busy !== 1'b1 || q !== 8'h3C || done !== 1'b0) begin
            errors++; $display("FAIL b2b_start busy %b q %h done %b exp 1 3c 0", busy, q, done);
        end
        start = 0; mode = 3'b000;
        cyc();
        checks++;
        if (q !== 8'h79 || done !== 1'b1 || busy !== 1'b0) begin
            errors++; $display("FAIL b2b_second q %h done %b busy %b exp 79 1 0", q, done, busy);
        end
        sin = 0;
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            rst   = ($urandom_range(0, 40) != 0);
            en    = ($urandom_range(0, 7) != 0);
            mode  = 3'($urandom_range(0, 7));
            start = ($urandom_range(0, 2) == 0);
            amt   = 4'($urandom_range(0, 15));
            d     = 8'($urandom);
            sin   = 1'($urandom);
            cyc();
            checks++;
            if (q !== m_q[7:0] || sout !== m_sout[0] || busy !== m_busy[0] || done !== m_done[0]) begin
                errors++;
                $display("FAIL rand%0d q %h sout %b busy %b done %b exp %h %b %b %b",
                         i, q, sout, busy, done, m_q[7:0], m_sout[0], m_busy[0], m_done[0]);
            end
        end
    endtask

    initial begin
        rst = 0; en = 1; mode = 0; start = 0; amt = 0; d = 0; sin = 0;
        m_q = 0; m_sout = 0; m_busy = 0; m_done = 0; m_cnt = 0; m_cmd = 0;
        test_reset();
        test_single_modes();
        test_multi();
        test_freeze();
        test_abort();
        test_back_to_back();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
